// File: rtl/neuron_mac_sched.sv
// neuron_mac_sched: evaluates a dense layer of N_OUT neurons (N_IN inputs each)
// on one shared 32-bit multiply-accumulate unit. The unit walks a weight/bias
// memory with a 1-cycle read latency. Each ReLU'd result is handed to the next
// layer over a valid/ready port.
module neuron_mac_sched #(
  parameter int N_IN  = 15,
  parameter int N_OUT = 4,
  parameter int AW    = 8,
  parameter int IW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [32*N_IN-1:0] a_flat,
  output logic [AW-1:0]     w_addr,
  input  logic [31:0]       w_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [IW-1:0]     y_idx,
  output logic [31:0]       y_data,
  output logic              busy,
  output logic              done
);

  // k runs 0..N_IN inclusive, so it needs room for N_IN itself
  localparam int KW = $clog2(N_IN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t        state_r;
  logic [31:0]   act_r [N_IN];
  logic [31:0]   acc_r;
  logic [IW-1:0] j_r;
  logic [KW-1:0] k_r;

  logic [31:0]   a_sel_s;
  logic [31:0]   prod_s;
  logic [31:0]   acc_bias_s;

  // Pick activation k-1: in a RUN cycle, w_data carries the word addressed one cycle earlier
  always_comb begin
    a_sel_s = 32'd0;
    for (int i = 0; i < N_IN; i++) begin
      a_sel_s = (k_r == KW'(i + 1)) ? act_r[i] : a_sel_s;
    end
    prod_s     = a_sel_s * w_data;
    acc_bias_s = acc_r + w_data;
  end

  // Scheduler FSM: address sequencing, accumulation and the registered output handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      acc_r   <= 32'd0;
      j_r     <= '0;
      k_r     <= '0;
      w_addr  <= '0;
      y_valid <= 1'b0;
      y_idx   <= '0;
      y_data  <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        act_r[i] <= 32'd0;
      end
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_IN; i++) begin
              act_r[i] <= a_flat[32*i +: 32];
            end
            j_r     <= '0;
            k_r     <= '0;
            acc_r   <= 32'd0;
            w_addr  <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          // k=0 has no data back from memory yet
          if (k_r != KW'(0)) begin
            acc_r <= acc_r + prod_s;
          end
          if (k_r == KW'(N_IN)) begin
            // bias address stays on the bus; its word arrives during DRAIN
            state_r <= DRAIN;
          end else begin
            k_r    <= k_r + KW'(1);
            w_addr <= w_addr + AW'(1);
          end
        end
        DRAIN: begin
          acc_r   <= acc_bias_s;
          y_valid <= 1'b1;
          y_idx   <= j_r;
          y_data  <= acc_bias_s[31] ? 32'd0 : acc_bias_s;
          state_r <= WRITE;
        end
        WRITE: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (j_r == IW'(N_OUT - 1)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= IDLE;
            end else begin
              // the bias of neuron j sits right below weight 0 of neuron j+1
              j_r     <= j_r + IW'(1);
              k_r     <= '0;
              acc_r   <= 32'd0;
              w_addr  <= w_addr + AW'(1);
              state_r <= RUN;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_sched.sv
// tb_neuron_mac_sched: scoreboard bench for neuron_mac_sched. Expected results
// come from a behavioural layer model. They are queued when a pass starts and
// popped when the DUT hands each result over.
module tb_neuron_mac_sched;

  localparam int N_IN  = 15;
  localparam int N_OUT = 4;
  localparam int AW    = 8;
  localparam int IW    = 2;
  localparam int NP    = N_IN + 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [32*N_IN-1:0] a_flat;
  logic [AW-1:0]      w_addr;
  logic [31:0]        w_data;
  logic               y_valid;
  logic               y_ready;
  logic [IW-1:0]      y_idx;
  logic [31:0]        y_data;
  logic               busy;
  logic               done;

  neuron_mac_sched #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .IW(IW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a_flat  (a_flat),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_idx   (y_idx),
    .y_data  (y_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [2**AW];
  logic [31:0] a_tb [N_IN];

  // weight memory with one cycle of read latency
  always @(posedge clk) w_data <= mem[w_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int e0 = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] data;
    logic        chk;
    logic [31:0] t;
  } exp_s;

  exp_s sb[$];
  exp_s mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference neuron: truncated products, wrapping sum, unscaled bias, ReLU
  function automatic logic [31:0] model(input int j);
    logic [63:0] p;
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < N_IN; k++) begin
      p   = {32'd0, a_tb[k]} * {32'd0, mem[j*(N_IN+1)+k]};
      acc = acc + p[31:0];
    end
    acc = acc + mem[j*(N_IN+1)+N_IN];
    return acc[31] ? 32'd0 : acc;
  endfunction

  // output monitor: every handshake pops one expected result
  always @(negedge clk) begin
    if (!reset) begin
      if (y_valid && y_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("y_idx", 32'(y_idx), mon_e.idx);
          check("y_data", y_data, mon_e.data);
          if (mon_e.chk) check("y_time", 32'(cyc - e0), mon_e.t);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_basic();
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'd0;
    for (int k = 0; k < N_IN; k++) begin
      a_tb[k]          = 32'd1;
      mem[k]           = 32'd2;
      mem[16 + k]      = 32'hFFFF_FFFF;
      mem[32 + k]      = $urandom_range(0, 300);
      mem[48 + k]      = $urandom_range(0, 300);
    end
    mem[15] = 32'd3;
    mem[31] = 32'd0;
    mem[47] = 32'd7;
    mem[63] = 32'hFFFF_F000;
  endtask

  // called just after a clock edge or a falling edge, with the DUT idle or pulsing done
  task automatic begin_pass(input logic chk);
    for (int k = 0; k < N_IN; k++) a_flat[32*k +: 32] = a_tb[k];
    for (int j = 0; j < N_OUT; j++) sb.push_back({32'(j), model(j), chk, 32'(j*NP + N_IN + 2)});
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    check("busy_after_E0", 32'(busy), 32'd1);
    check("done_after_E0", 32'(done), 32'd0);
    check("w_addr_E0", 32'(w_addr), 32'd0);
  endtask

  // returns in the done cycle, after its falling edge, so start can still be chained
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("done_once", 32'(done_cnt), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int acc_c;
    reset   = 1'b1;
    start   = 1'b0;
    y_ready = 1'b1;
    a_flat  = '0;
    load_basic();
    repeat (3) @(posedge clk);
    #1;
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y_idx", 32'(y_idx), 32'd0);
    check("rst_y_data", y_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // basic/ReLU pass with a stray start and an a_flat change after capture
    begin_pass(1'b1);
    repeat (3) begin @(posedge clk); #1; end
    a_flat = {N_IN{32'hDEAD_BEEF}};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // chained start in the done cycle; neuron 1 bias 20 gives 5
    mem[31] = 32'd20;
    begin_pass(1'b1);
    wait_done();

    // backpressure on neuron 0
    mem[31] = 32'd0;
    y_ready = 1'b0;
    begin_pass(1'b0);
    n = 0;
    while (!y_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("bp_valid", 32'(y_valid), 32'd1);
    check("bp_time", 32'(cyc - e0), 32'd17);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(y_valid), 32'd1);
      check("bp_hold_data", y_data, 32'd33);
      check("bp_hold_idx", 32'(y_idx), 32'd0);
      check("bp_hold_addr", 32'(w_addr), 32'd15);
      @(posedge clk);
      #1;
    end
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    acc_c = cyc;
    check("bp_next_addr", 32'(w_addr), 32'd16);
    check("bp_valid_drop", 32'(y_valid), 32'd0);
    n = 0;
    while (!y_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("bp_n1_time", 32'(cyc - acc_c), 32'd17);
    wait_done();

    // reset in the middle of neuron 2's RUN
    begin_pass(1'b1);
    repeat (41) begin @(posedge clk); #1; end
    check("mid_w_addr", 32'(w_addr), 32'd37);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    check("mr_w_addr", 32'(w_addr), 32'd0);
    check("mr_y_valid", 32'(y_valid), 32'd0);
    check("mr_y_idx", 32'(y_idx), 32'd0);
    check("mr_y_data", y_data, 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    check("mr_no_result", 32'(y_valid), 32'd0);
    check("mr_still_idle", 32'(busy), 32'd0);

    // wrap: 0x10000 * 0x10000 truncates to 0, bias 5 survives
    a_tb[0] = 32'h0001_0000;
    for (int k = 1; k < N_IN; k++) a_tb[k] = $urandom_range(0, 1000);
    mem[0] = 32'h0001_0000;
    for (int k = 1; k < N_IN; k++) mem[k] = 32'd0;
    mem[15] = 32'd5;
    begin_pass(1'b1);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
